// File: rtl/apb_cfg_master_pkg.sv
// apb_cfg_master_pkg: shared FSM state and request/response types for the APB configuration initiator
package apb_cfg_master_pkg;
  localparam int AW = 32;
  localparam int DW = 32;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic          write;
    logic [DW-1:0] wdata;
  } req_t;
  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
    logic          timeout;
  } rsp_t;
endpackage

// File: rtl/apb_cfg_master_timeout.sv
// apb_cfg_master_timeout: saturating stall counter that flags the LIMIT-th stalled ACCESS cycle
// Ports: i_clk, i_rst (sync, active-high), i_clr (zero the count), i_en (count a stalled cycle),
// o_expired (high in the stalled cycle that reaches LIMIT).
module apb_cfg_master_timeout #(
  parameter int LIMIT = 256
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] MAX = W'(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  logic [W-1:0] r_cnt;
  always_ff @(posedge i_clk)
    if (i_rst || i_clr) r_cnt <= '0;
    else if (i_en && r_cnt != MAX) r_cnt <= r_cnt + 1'b1;
  // the count holds the stalls already seen, so the current stall is number r_cnt+1
  assign o_expired = i_en && r_cnt == LAST;
endmodule

// File: rtl/apb_cfg_master.sv
// apb_cfg_master: single-outstanding APB3 initiator for configuration reads/writes
// Ports: clk_i, rst_i (sync, active-high); req_* valid/ready request (write, addr, wdata);
// rsp_* valid/ready response (rdata, err, timeout); psel/penable/pwrite/paddr/pwdata out,
// prdata/pready/pslverr in. Define APB_CFG_MASTER_TIMEOUT_EN to abort stalled ACCESS phases.
module apb_cfg_master
  import apb_cfg_master_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_write_i,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      rsp_timeout_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);
  state_e r_state, w_next;
  logic [APB_ADDR_WIDTH-1:0] r_addr;
  logic [APB_DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic r_write, r_err, w_expired, w_done;
`ifdef APB_CFG_MASTER_TIMEOUT_EN
  logic r_to;
  apb_cfg_master_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .i_clk     (clk_i),
    .i_rst     (rst_i),
    .i_clr     (r_state == SETUP),
    .i_en      (r_state == ACCESS && !pready_i),
    .o_expired (w_expired)
  );
  assign rsp_timeout_o = r_to;
`else
  assign w_expired = 1'b0;
  assign rsp_timeout_o = 1'b0;
`endif
  // a ready slave beats the timeout when both land in the same cycle
  assign w_done = r_state == ACCESS && (pready_i || w_expired);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = req_valid_i ? SETUP : IDLE;
      SETUP:   w_next = ACCESS;
      ACCESS:  w_next = w_done ? RESP : ACCESS;
      RESP:    w_next = rsp_ready_i ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
    req_ready_o = r_state == IDLE;
    psel_o      = r_state == SETUP || r_state == ACCESS;
    penable_o   = r_state == ACCESS;
    rsp_valid_o = r_state == RESP;
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
`ifdef APB_CFG_MASTER_TIMEOUT_EN
      r_to    <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && req_valid_i) begin
        r_addr  <= req_addr_i;
        r_write <= req_write_i;
        r_wdata <= req_wdata_i;
      end
      if (w_done) begin
        r_err   <= pready_i ? pslverr_i : 1'b1;
        r_rdata <= (pready_i && !r_write && !pslverr_i) ? prdata_i : '0;
`ifdef APB_CFG_MASTER_TIMEOUT_EN
        r_to    <= !pready_i;
`endif
      end
    end
  assign paddr_o     = r_addr;
  assign pwrite_o    = r_write;
  assign pwdata_o    = r_wdata;
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;
endmodule

// File: tb/tb_apb_cfg_master.sv
// tb_apb_cfg_master: table-driven and randomized transactions checked against a transaction-level model
module tb_apb_cfg_master;
  localparam int TMO = 4;
`ifdef APB_CFG_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_i = 1'b1;
  logic req_valid_i = 1'b0, req_ready_o, req_write_i = 1'b0;
  logic [31:0] req_addr_i = '0, req_wdata_i = '0;
  logic rsp_valid_o, rsp_ready_i = 1'b0, rsp_err_o, rsp_timeout_o;
  logic [31:0] rsp_rdata_o;
  logic psel_o, penable_o, pwrite_o;
  logic [31:0] paddr_o, pwdata_o, prdata_i = '0;
  logic pready_i = 1'b0, pslverr_i = 1'b0;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  apb_cfg_master #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
  );
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          waits;
    logic        slverr;
    int          hold;
  } txn_t;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // One transfer, driven from the slave side with the given wait states; every expectation
  // comes from the transaction's own rules (ACCESS length, latency, response fields).
  task automatic do_txn(input txn_t t);
    logic exp_to, exp_err;
    logic [31:0] exp_rd;
    int exp_acc, acc, rsp_cyc;
    exp_to  = TO_EN && t.waits >= TMO;
    exp_acc = exp_to ? TMO : t.waits + 1;
    exp_err = exp_to || t.slverr;
    exp_rd  = (exp_to || t.wr || t.slverr) ? 32'h0 : t.prdata;
    check("idle_req_ready", req_ready_o, 1);
    req_valid_i = 1'b1; req_write_i = t.wr; req_addr_i = t.addr; req_wdata_i = t.wdata;
    rsp_ready_i = 1'b0;
    @(negedge clk);
    req_valid_i = 1'b0; req_write_i = 1'($urandom); req_addr_i = $urandom; req_wdata_i = $urandom;
    acc = 0; rsp_cyc = 0;
    for (int cyc = 1; cyc < 400 && rsp_cyc == 0; cyc++) begin
      if (rsp_valid_o) rsp_cyc = cyc;
      else begin
        if (penable_o) acc++;
        check("apb_psel", psel_o, 1);
        check("apb_penable", penable_o, cyc > 1);
        check("apb_req_ready_busy", req_ready_o, 0);
        check("apb_paddr", paddr_o, t.addr);
        check("apb_pwrite", pwrite_o, t.wr);
        check("apb_pwdata", pwdata_o, t.wdata);
        pready_i  = penable_o ? (acc == t.waits + 1) : 1'($urandom);
        pslverr_i = (penable_o && pready_i) ? t.slverr : 1'($urandom);
        prdata_i  = (penable_o && pready_i) ? t.prdata : $urandom;
        @(negedge clk);
      end
    end
    if (rsp_cyc == 0) begin
      check("rsp_wait_expired", 0, 1);
      return;
    end
    check("access_cycles", acc, exp_acc);
    check("rsp_latency", rsp_cyc, exp_acc + 2);
    pready_i = 1'($urandom); pslverr_i = 1'($urandom); prdata_i = $urandom;
    for (int h = 0; h <= t.hold; h++) begin
      if (h > 0) @(negedge clk);
      check("rsp_valid", rsp_valid_o, 1);
      check("rsp_rdata", rsp_rdata_o, exp_rd);
      check("rsp_err", rsp_err_o, exp_err);
      check("rsp_timeout", rsp_timeout_o, exp_to);
      check("rsp_psel", psel_o, 0);
      check("rsp_penable", penable_o, 0);
      check("rsp_req_ready", req_ready_o, 0);
      pready_i = 1'($urandom); pslverr_i = 1'($urandom); prdata_i = $urandom;
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0; pready_i = 1'b0; pslverr_i = 1'b0;
    check("post_rsp_valid", rsp_valid_o, 0);
    check("post_req_ready", req_ready_o, 1);
    check("post_psel", psel_o, 0);
    check("hold_paddr", paddr_o, t.addr);
    check("hold_pwrite", pwrite_o, t.wr);
    check("hold_pwdata", pwdata_o, t.wdata);
  endtask
  initial begin
    #500000;
    $display("FAIL global_watchdog expired");
    $fatal(1);
  end
  initial begin
    txn_t vec[7];
    txn_t r;
    vec[0] = '{1'b1, 32'h0000_0010, 32'h1234_5678, 32'hFFFF_FFFF, 0,  1'b0, 0};
    vec[1] = '{1'b0, 32'h0000_0020, 32'h0,         32'hCAFE_F00D, 3,  1'b0, 1};
    vec[2] = '{1'b0, 32'h0000_0030, 32'h0,         32'hDEAD_BEEF, 1,  1'b1, 5};
    vec[3] = '{1'b1, 32'h0000_0034, 32'h0BAD_0BAD, 32'h1111_2222, 2,  1'b1, 0};
    vec[4] = '{1'b0, 32'h0000_0040, 32'h0,         32'h5555_AAAA, 10, 1'b0, 0};
    vec[5] = '{1'b0, 32'h0000_0044, 32'h0,         32'h0F0F_F0F0, 3,  1'b0, 0};
    vec[6] = '{1'b1, 32'h0000_0048, 32'h7777_8888, 32'h0,         4,  1'b0, 2};
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_psel", psel_o, 0);
    check("rst_penable", penable_o, 0);
    check("rst_paddr", paddr_o, 0);
    check("rst_pwdata", pwdata_o, 0);
    check("rst_pwrite", pwrite_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_rdata", rsp_rdata_o, 0);
    check("rst_rsp_err", rsp_err_o, 0);
    check("rst_rsp_timeout", rsp_timeout_o, 0);
    check("rst_req_ready", req_ready_o, 1);
    for (int i = 0; i < 7; i++) do_txn(vec[i]);
    // reset in the middle of an ACCESS phase abandons the transfer
    req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h0000_0050;
    @(negedge clk);
    req_valid_i = 1'b0; pready_i = 1'b0;
    @(negedge clk);
    check("mid_access_penable", penable_o, 1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("midrst_psel", psel_o, 0);
    check("midrst_penable", penable_o, 0);
    check("midrst_rsp_valid", rsp_valid_o, 0);
    check("midrst_req_ready", req_ready_o, 1);
    r = '{1'b1, 32'h0000_0054, 32'hA1B2_C3D4, 32'h0, 0, 1'b0, 0};
    do_txn(r);
    // back-to-back with request valid and response ready held high
    req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 32'h0000_0100; req_wdata_i = 32'hA5A5_0001;
    rsp_ready_i = 1'b1; pready_i = 1'b1; pslverr_i = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check("b2b_psel", psel_o, c == 1 || c == 2 || c == 5 || c == 6);
      check("b2b_penable", penable_o, c == 2 || c == 6);
      check("b2b_rsp_valid", rsp_valid_o, c == 3 || c == 7);
      check("b2b_req_ready", req_ready_o, c == 4 || c == 8);
      check("b2b_paddr", paddr_o, c < 5 ? 32'h0000_0100 : 32'h0000_0104);
      check("b2b_pwdata", pwdata_o, c < 5 ? 32'hA5A5_0001 : 32'hA5A5_0002);
      if (c == 1) begin req_addr_i = 32'h0000_0104; req_wdata_i = 32'hA5A5_0002; end
      if (c == 7) req_valid_i = 1'b0;
    end
    rsp_ready_i = 1'b0; pready_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      r.wr     = 1'($urandom);
      r.addr   = $urandom;
      r.wdata  = $urandom;
      r.prdata = $urandom;
      r.waits  = $urandom_range(0, 6);
      r.slverr = $urandom_range(0, 3) == 0;
      r.hold   = $urandom_range(0, 3);
      do_txn(r);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
